// File: rtl/pkg_global.sv
// Shared definitions for the SPI sequencer slice: FSM state encoding and default widths.
package pkg_global;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        START,
        WAIT,
        STORE,
        FINISH
    } seq_state_e;

endpackage

// File: rtl/module_seq_counter.sv
// Transfer index counter for the SPI sequencer, with the end-of-burst limit captured at start.
module module_seq_counter #(
    parameter int ADDR_W = pkg_global::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] end_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              last_o,
    output logic [ADDR_W:0]   n_done_o
);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] end_q;

    // The increment is blocked on the last index so the address never passes the latched end.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            end_q   <= '0;
        end else if (clear_i) begin
            count_q <= '0;
            end_q   <= end_i;
        end else if (inc_i && !last_o) begin
            count_q <= count_q + ADDR_W'(1);
        end
    end

    assign count_o  = count_q;
    assign last_o   = (count_q == end_q);
    assign n_done_o = {1'b0, count_q} + {{ADDR_W{1'b0}}, 1'b1};

endmodule

// File: rtl/module_spi_sequencer.sv
// Steps RAM bytes through an SPI engine and stores the replies back in place.
// Optional WAIT watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module module_spi_sequencer #(
    parameter int DATA_W         = pkg_global::DATA_W,
    parameter int ADDR_W         = pkg_global::ADDR_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              send_i,
    input  logic              all_1s_i,
    input  logic              all_0s_i,
    input  logic [ADDR_W-1:0] n_tx_end_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              spi_done_i,
    input  logic [DATA_W-1:0] spi_rx_i,
    output logic              spi_start_o,
    output logic [DATA_W-1:0] spi_tx_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              busy_o,
    output logic              ctrl_we_o,
    output logic [ADDR_W:0]   n_rx_o,
    output logic              err_o
);

    import pkg_global::*;

    seq_state_e state_q, state_d;

    logic              all_1s_q;
    logic              all_0s_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [ADDR_W:0]   n_rx_q;

    logic              start_seq;
    logic [ADDR_W-1:0] count;
    logic              last;
    logic [ADDR_W:0]   n_done;
    logic              timeout;

    assign start_seq = (state_q == IDLE) && send_i;

    module_seq_counter #(
        .ADDR_W (ADDR_W)
    ) u_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (start_seq),
        .end_i    (n_tx_end_i),
        .inc_i    (state_q == STORE),
        .count_o  (count),
        .last_o   (last),
        .n_done_o (n_done)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Counts WAIT cycles; the limit is hit on the TIMEOUT_CYCLES-th cycle without a done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q <= '0;
        end else if (state_q == START) begin
            wd_q <= '0;
        end else if (state_q == WAIT) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    assign timeout = (state_q == WAIT) && !spi_done_i && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (start_seq) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (send_i) state_d = READ;
            READ:    state_d = LATCH;
            LATCH:   state_d = START;
            START:   state_d = WAIT;
            WAIT: begin
                if (spi_done_i) begin
                    state_d = STORE;
                end else if (timeout) begin
                    state_d = FINISH;
                end
            end
            STORE:   state_d = last ? FINISH : READ;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Mode bits are sampled once at start so register changes mid-burst have no effect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            all_1s_q <= 1'b0;
            all_0s_q <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            n_rx_q   <= '0;
        end else begin
            if (start_seq) begin
                all_1s_q <= all_1s_i;
                all_0s_q <= all_0s_i;
                n_rx_q   <= '0;
            end
            if (state_q == LATCH) begin
                if (all_1s_q) begin
                    tx_q <= '1;
                end else if (all_0s_q) begin
                    tx_q <= '0;
                end else begin
                    tx_q <= ram_rdata_i;
                end
            end
            if ((state_q == WAIT) && spi_done_i) begin
                rx_q <= spi_rx_i;
            end
            if ((state_q == STORE) && last) begin
                n_rx_q <= n_done;
            end
            // A timed-out transfer is not counted as completed.
            if (timeout) begin
                n_rx_q <= {1'b0, count};
            end
        end
    end

    assign spi_start_o = (state_q == START);
    assign spi_tx_o    = tx_q;
    assign ram_addr_o  = count;
    assign ram_we_o    = (state_q == STORE);
    assign ram_wdata_o = rx_q;
    assign busy_o      = (state_q != IDLE);
    assign ctrl_we_o   = (state_q == FINISH);
    assign n_rx_o      = n_rx_q;

endmodule

// File: tb/tb_module_spi_sequencer.sv
// Scoreboard bench for module_spi_sequencer with a RAM model and a reply-generating SPI engine model.
module tb_module_spi_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 9;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              send_i;
    logic              all_1s_i;
    logic              all_0s_i;
    logic [ADDR_W-1:0] n_tx_end_i;
    logic [DATA_W-1:0] ram_rdata_i;
    logic              spi_done_i;
    logic [DATA_W-1:0] spi_rx_i;
    logic              spi_start_o;
    logic [DATA_W-1:0] spi_tx_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_we_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic              busy_o;
    logic              ctrl_we_o;
    logic [ADDR_W:0]   n_rx_o;
    logic              err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0]        ram     [0:511];
    logic [DATA_W-1:0]        exp_mem [0:511];
    logic [DATA_W-1:0]        exp_tx_q  [$];
    logic [ADDR_W+DATA_W-1:0] exp_wr_q  [$];
    logic [ADDR_W:0]          exp_nrx_q [$];
    logic                     exp_err = 1'b0;

    int finish_seen  = 0;
    int starts_seen  = 0;
    int neg_cycles   = 0;
    int start_cycle  = 0;
    int finish_cycle = 0;

    int   eng_delay  = 8;
    bit   eng_enable = 1'b1;
    logic eng_active;
    int   eng_cnt;
    logic [DATA_W-1:0] eng_tx;

    module_spi_sequencer #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .send_i      (send_i),
        .all_1s_i    (all_1s_i),
        .all_0s_i    (all_0s_i),
        .n_tx_end_i  (n_tx_end_i),
        .ram_rdata_i (ram_rdata_i),
        .spi_done_i  (spi_done_i),
        .spi_rx_i    (spi_rx_i),
        .spi_start_o (spi_start_o),
        .spi_tx_o    (spi_tx_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_wdata_o (ram_wdata_o),
        .busy_o      (busy_o),
        .ctrl_we_o   (ctrl_we_o),
        .n_rx_o      (n_rx_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read RAM; the sequencer is its only writer once a test is running.
    always @(posedge clk_i) begin
        if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
        ram_rdata_i <= ram[ram_addr_o];
    end

    // SPI engine: answers each start after eng_delay cycles with the sent byte XOR 0x99.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eng_active <= 1'b0;
            eng_cnt    <= 0;
            eng_tx     <= '0;
            spi_done_i <= 1'b0;
            spi_rx_i   <= '0;
        end else begin
            spi_done_i <= 1'b0;
            if (spi_start_o && eng_enable) begin
                eng_active <= 1'b1;
                eng_cnt    <= eng_delay;
                eng_tx     <= spi_tx_o;
            end else if (eng_active) begin
                if (eng_cnt <= 1) begin
                    spi_done_i <= 1'b1;
                    spi_rx_i   <= eng_tx ^ 8'h99;
                    eng_active <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Monitor pops the scoreboard whenever the DUT emits a start, a RAM write or a write-back.
    always @(negedge clk_i) begin
        neg_cycles++;
        if (rst_ni) begin
            if (spi_start_o) begin
                starts_seen++;
                start_cycle = neg_cycles;
                if (exp_tx_q.size() == 0) check_output("tx_unexpected", 32'd1, 32'd0);
                else check_output("spi_tx", 32'(spi_tx_o), 32'(exp_tx_q.pop_front()));
            end
            if (ram_we_o) begin
                if (exp_wr_q.size() == 0) check_output("wr_unexpected", 32'd1, 32'd0);
                else check_output("ram_write", 32'({ram_addr_o, ram_wdata_o}), 32'(exp_wr_q.pop_front()));
            end
            if (ctrl_we_o) begin
                finish_seen++;
                finish_cycle = neg_cycles;
                if (exp_nrx_q.size() == 0) check_output("ctrl_unexpected", 32'd1, 32'd0);
                else check_output("n_rx", 32'(n_rx_o), 32'(exp_nrx_q.pop_front()));
                check_output("err_at_finish", 32'(err_o), 32'(exp_err));
            end
        end
    end

    task automatic fill_ram(input bit random_fill, input logic [DATA_W-1:0] base);
        for (int i = 0; i < 512; i++) begin
            logic [DATA_W-1:0] v;
            v = random_fill ? DATA_W'($urandom_range(0, 255)) : base + DATA_W'(i);
            ram[i]     <= v;
            exp_mem[i] = v;
        end
        @(negedge clk_i);
    endtask

    task automatic push_expect(input int n_end, input bit a1, input bit a0);
        for (int i = 0; i <= n_end; i++) begin
            logic [DATA_W-1:0] tx;
            tx = a1 ? 8'hFF : (a0 ? 8'h00 : exp_mem[i]);
            exp_tx_q.push_back(tx);
            exp_wr_q.push_back({ADDR_W'(i), tx ^ 8'h99});
        end
        exp_nrx_q.push_back((ADDR_W + 1)'(n_end + 1));
    endtask

    // Raises send for one cycle, then scrambles the config inputs to show they were latched.
    task automatic apply_stimulus(input int n_end, input bit a1, input bit a0);
        @(negedge clk_i);
        n_tx_end_i = ADDR_W'(n_end);
        all_1s_i   = a1;
        all_0s_i   = a0;
        send_i     = 1'b1;
        @(negedge clk_i);
        send_i     = 1'b0;
        n_tx_end_i = ~ADDR_W'(n_end);
        all_1s_i   = ~a1;
        all_0s_i   = ~a0;
    endtask

    task automatic wait_finish(input string tag, input int budget);
        int base;
        bit seen;
        base = finish_seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk_i);
            #1;
            if (finish_seen != base) seen = 1'b1;
        end
        if (!seen) begin
            check_output({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_output({tag, "_busy_after"}, 32'(busy_o), 32'd0);
            check_output({tag, "_queues_empty"},
                         32'(exp_tx_q.size() + exp_wr_q.size() + exp_nrx_q.size()), 32'd0);
        end
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rst_ni     = 1'b0;
        send_i     = 1'b0;
        all_1s_i   = 1'b0;
        all_0s_i   = 1'b0;
        n_tx_end_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_output("rst_busy", 32'(busy_o), 32'd0);
        check_output("rst_strobes", 32'({spi_start_o, ram_we_o, ctrl_we_o, err_o}), 32'd0);
        check_output("rst_data", 32'({spi_tx_o, ram_wdata_o, ram_addr_o}), 32'd0);
        check_output("rst_n_rx", 32'(n_rx_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] single transfer");
        fill_ram(1'b1, 8'h00);
        ram[0]     <= 8'hA5;
        exp_mem[0] = 8'hA5;
        @(negedge clk_i);
        eng_delay = 8;
        exp_tx_q.push_back(8'hA5);
        exp_wr_q.push_back({9'd0, 8'h3C});
        exp_nrx_q.push_back(10'd1);
        apply_stimulus(0, 1'b0, 1'b0);
        wait_finish("single", 100);
        check_output("single_ram0", 32'(ram[0]), 32'h3C);
        check_output("single_n_rx_hold", 32'(n_rx_o), 32'd1);

        $display("[TB] burst of four");
        fill_ram(1'b0, 8'h01);
        eng_delay = 3;
        push_expect(3, 1'b0, 1'b0);
        apply_stimulus(3, 1'b0, 1'b0);
        wait_finish("burst", 200);
        check_output("burst_ram3", 32'(ram[3]), 32'(8'h04 ^ 8'h99));

        $display("[TB] override both set");
        fill_ram(1'b1, 8'h00);
        push_expect(1, 1'b1, 1'b1);
        apply_stimulus(1, 1'b1, 1'b1);
        wait_finish("ovr_both", 200);

        $display("[TB] override zeros");
        fill_ram(1'b1, 8'h00);
        eng_delay = 5;
        push_expect(1, 1'b0, 1'b1);
        apply_stimulus(1, 1'b0, 1'b1);
        wait_finish("ovr_zero", 200);

        $display("[TB] abort during second transfer");
        fill_ram(1'b0, 8'h40);
        eng_delay = 8;
        exp_tx_q.push_back(exp_mem[0]);
        exp_tx_q.push_back(exp_mem[1]);
        exp_wr_q.push_back({9'd0, exp_mem[0] ^ 8'h99});
        begin
            int base;
            bit seen;
            base = starts_seen;
            seen = 1'b0;
            apply_stimulus(3, 1'b0, 1'b0);
            for (int c = 0; c < 100 && !seen; c++) begin
                @(posedge clk_i);
                if (starts_seen >= base + 2) seen = 1'b1;
            end
            check_output("abort_second_start", 32'(seen), 32'd1);
        end
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check_output("abort_busy", 32'(busy_o), 32'd0);
        check_output("abort_strobes", 32'({spi_start_o, ram_we_o, ctrl_we_o}), 32'd0);
        check_output("abort_data", 32'({spi_tx_o, ram_addr_o, n_rx_o}), 32'd0);
        repeat (2) @(negedge clk_i);
        check_output("abort_ram1_kept", 32'(ram[1]), 32'(exp_mem[1]));
        check_output("abort_queues", 32'(exp_tx_q.size() + exp_wr_q.size()), 32'd0);
        rst_ni = 1'b1;
        fill_ram(1'b1, 8'h00);
        push_expect(0, 1'b0, 1'b0);
        apply_stimulus(0, 1'b0, 1'b0);
        wait_finish("restart", 100);

        $display("[TB] full-depth boundary");
        fill_ram(1'b1, 8'h00);
        eng_delay = 1;
        push_expect(511, 1'b0, 1'b0);
        apply_stimulus(511, 1'b0, 1'b0);
        wait_finish("boundary", 10000);
        check_output("boundary_n_rx_hold", 32'(n_rx_o), 32'd512);
        check_output("boundary_last_addr", 32'(ram_addr_o), 32'd511);

`ifdef SPI_SEQ_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        fill_ram(1'b1, 8'h00);
        eng_enable = 1'b0;
        exp_err    = 1'b1;
        exp_tx_q.push_back(exp_mem[0]);
        exp_nrx_q.push_back(10'd0);
        apply_stimulus(0, 1'b0, 1'b0);
        wait_finish("timeout", 600);
        check_output("timeout_wait_len", 32'(finish_cycle - start_cycle), 32'd257);
        check_output("timeout_err_sticky", 32'(err_o), 32'd1);
        eng_enable = 1'b1;
        exp_err    = 1'b0;
`endif

        check_output("err_idle", 32'(err_o), 32'd0 | 32'(exp_err));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
